// File: rtl/ssb_sync_gen.sv
`default_nettype none
// ============================================================================
// ssb_sync_gen : streams the PSS then the SSS frequency-domain symbol, 1 bin/beat
// Rev 1.0
// ============================================================================
module ssb_sync_gen #(
    parameter int NFFT   = 256,
    parameter int OUT_DW = 32,
    parameter int AMP    = 8192
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [10:0]       s_axis_ctrl_tdata,
    input  logic              s_axis_ctrl_tvalid,
    output logic              s_axis_ctrl_tready,
    output logic [OUT_DW-1:0] m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    input  logic              m_axis_out_tready,
    output logic              m_axis_out_tlast,
    output logic              m_axis_out_tuser,
    output logic              busy_o,
    output logic              error_o
);
    localparam int              KW      = $clog2(NFFT);
    localparam int              HW      = OUT_DW / 2;
    localparam logic [KW-1:0]   K_LO    = KW'(NFFT / 2 - 63);
    localparam logic [KW-1:0]   K_HI    = KW'(NFFT / 2 + 63);
    localparam logic [KW-1:0]   K_LAST  = KW'(NFFT - 1);
    localparam logic [HW-1:0]   AMP_POS = HW'(AMP);
    localparam logic [HW-1:0]   AMP_NEG = HW'(-AMP);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PSS  = 2'd1;
    localparam logic [1:0] ST_SSS  = 2'd2;

    function automatic logic [126:0] mseq(input logic [6:0] init, input int tap);
        logic [126:0] s;
        s      = '0;
        s[6:0] = init;
        for (int i = 0; i < 120; i++) s[i+7] = s[i+tap] ^ s[i];
        return s;
    endfunction

    function automatic logic [6:0] inc127(input logic [6:0] v);
        return (v == 7'd126) ? 7'd0 : v + 7'd1;
    endfunction

    localparam logic [126:0] X_SEQ  = mseq(7'b1110110, 4);
    localparam logic [126:0] X0_SEQ = mseq(7'b0000001, 4);
    localparam logic [126:0] X1_SEQ = mseq(7'b0000001, 1);

    logic [1:0]        state_q, state_d;
    logic [KW-1:0]     gen_k_q, gen_k_d;
    logic              gen_sss_q, gen_sss_d;
    logic [6:0]        idx_a_q, idx_a_d, idx_b_q, idx_b_d;
    logic [6:0]        m0_q, m0_d, m1_q, m1_d;
    logic [OUT_DW-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic              error_q, error_d;

    logic [8:0] nid1;
    logic [1:0] nid2;
    logic       id_ok, ctrl_hs, out_hs, in_band, seq_bit;
    logic [6:0] pss_off, grp_off, nid2_off, m0_acc, m1_acc;

    assign nid1    = s_axis_ctrl_tdata[10:2];
    assign nid2    = s_axis_ctrl_tdata[1:0];
    assign id_ok   = (nid2 != 2'd3) && (nid1 <= 9'd335);
    assign ctrl_hs = s_axis_ctrl_tvalid && (state_q == ST_IDLE);
    assign out_hs  = tvalid_q && m_axis_out_tready;
    assign in_band = (gen_k_q >= K_LO) && (gen_k_q <= K_HI);
    assign seq_bit = gen_sss_q ? (X0_SEQ[idx_a_q] ^ X1_SEQ[idx_b_q]) : X_SEQ[idx_a_q];

    // Per-request offsets; the N_id_1 group is resolved by comparison only
    always_comb begin
        grp_off = 7'd0;
        m1_acc  = nid1[6:0];
        if (nid1 >= 9'd224) begin
            grp_off = 7'd30;
            m1_acc  = 7'(nid1 - 9'd224);
        end else if (nid1 >= 9'd112) begin
            grp_off = 7'd15;
            m1_acc  = 7'(nid1 - 9'd112);
        end
        case (nid2)
            2'd1:    begin pss_off = 7'd43; nid2_off = 7'd5;  end
            2'd2:    begin pss_off = 7'd86; nid2_off = 7'd10; end
            default: begin pss_off = 7'd0;  nid2_off = 7'd0;  end
        endcase
        m0_acc = grp_off + nid2_off;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ctrl_hs && id_ok)      state_d = ST_PSS;
            ST_PSS:  if (out_hs && tlast_q)     state_d = ST_SSS;
            ST_SSS:  if (out_hs && tlast_q)     state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // The generator runs one bin ahead of the output register; bin 0 is
    // always out-of-band (NFFT >= 128), so the accept edge loads a zero bin.
    always_comb begin
        gen_k_d   = gen_k_q;
        gen_sss_d = gen_sss_q;
        idx_a_d   = idx_a_q;
        idx_b_d   = idx_b_q;
        m0_d      = m0_q;
        m1_d      = m1_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        error_d   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ctrl_hs && id_ok) begin
                tvalid_d  = 1'b1;
                tdata_d   = '0;
                tlast_d   = 1'b0;
                tuser_d   = 1'b0;
                gen_k_d   = KW'(1);
                gen_sss_d = 1'b0;
                idx_a_d   = pss_off;
                idx_b_d   = 7'd0;
                m0_d      = m0_acc;
                m1_d      = m1_acc;
            end else if (ctrl_hs) begin
                error_d = 1'b1;
            end
        end else if (out_hs) begin
            if (tlast_q && tuser_q) begin
                tvalid_d = 1'b0;
                tdata_d  = '0;
                tlast_d  = 1'b0;
                tuser_d  = 1'b0;
            end else begin
                tdata_d = '0;
                if (in_band) tdata_d[HW-1:0] = seq_bit ? AMP_NEG : AMP_POS;
                tlast_d = (gen_k_q == K_LAST);
                tuser_d = gen_sss_q;
                if (gen_k_q == K_LAST) begin
                    gen_k_d   = '0;
                    gen_sss_d = 1'b1;
                    idx_a_d   = m0_q;
                    idx_b_d   = m1_q;
                end else begin
                    gen_k_d = gen_k_q + KW'(1);
                    if (in_band) begin
                        idx_a_d = inc127(idx_a_q);
                        idx_b_d = inc127(idx_b_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            gen_k_q   <= '0;
            gen_sss_q <= 1'b0;
            idx_a_q   <= '0;
            idx_b_q   <= '0;
            m0_q      <= '0;
            m1_q      <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            gen_k_q   <= gen_k_d;
            gen_sss_q <= gen_sss_d;
            idx_a_q   <= idx_a_d;
            idx_b_q   <= idx_b_d;
            m0_q      <= m0_d;
            m1_q      <= m1_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            error_q   <= error_d;
        end
    end

    assign s_axis_ctrl_tready = (state_q == ST_IDLE);
    assign busy_o             = (state_q != ST_IDLE);
    assign error_o            = error_q;
    assign m_axis_out_tdata   = tdata_q;
    assign m_axis_out_tvalid  = tvalid_q;
    assign m_axis_out_tlast   = tlast_q;
    assign m_axis_out_tuser   = tuser_q;

endmodule
`default_nettype wire

// File: tb/tb_ssb_sync_gen.sv
`default_nettype none
// ============================================================================
// tb_ssb_sync_gen : randomized checks of ssb_sync_gen against a formula model
// Rev 1.0
// ============================================================================
module tb_ssb_sync_gen;
    localparam int NFFT   = 256;
    localparam int OUT_DW = 32;
    localparam int AMP    = 8192;
    localparam int BW     = OUT_DW + 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [10:0]       ctrl_tdata = '0;
    logic              ctrl_tvalid = 1'b0;
    logic              ctrl_tready;
    logic [OUT_DW-1:0] out_tdata;
    logic              out_tvalid;
    logic              out_tready = 1'b1;
    logic              out_tlast, out_tuser, busy, err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int xs[127], x0s[127], x1s[127];
    int reqs[8];
    int nreq;
    int acc_edge[8];
    logic [BW-1:0] bq[$];
    int bq_cyc[$];
    int err_cyc[$];
    bit saw_valid, saw_busy;
    int stab_err;

    ssb_sync_gen #(.NFFT(NFFT), .OUT_DW(OUT_DW), .AMP(AMP)) dut (
        .clk_i              (clk),
        .reset_ni           (reset_n),
        .s_axis_ctrl_tdata  (ctrl_tdata),
        .s_axis_ctrl_tvalid (ctrl_tvalid),
        .s_axis_ctrl_tready (ctrl_tready),
        .m_axis_out_tdata   (out_tdata),
        .m_axis_out_tvalid  (out_tvalid),
        .m_axis_out_tready  (out_tready),
        .m_axis_out_tlast   (out_tlast),
        .m_axis_out_tuser   (out_tuser),
        .busy_o             (busy),
        .error_o            (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic build_seqs();
        int xi[7], x0i[7];
        xi  = '{0, 1, 1, 0, 1, 1, 1};
        x0i = '{1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            xs[i] = xi[i]; x0s[i] = x0i[i]; x1s[i] = x0i[i];
        end
        for (int i = 0; i < 120; i++) begin
            xs[i+7]  = xs[i+4]  ^ xs[i];
            x0s[i+7] = x0s[i+4] ^ x0s[i];
            x1s[i+7] = x1s[i+1] ^ x1s[i];
        end
    endtask

    // Reference bin: {tuser, tlast, tdata} from the cell-ID formulas
    function automatic logic [BW-1:0] model_beat(int nid1, int nid2, int sym, int k);
        logic [BW-1:0] r;
        int n, b, m0, m1, v;
        r = '0;
        r[OUT_DW+1] = (sym == 1);
        r[OUT_DW]   = (k == NFFT - 1);
        if (k < NFFT / 2 - 63 || k > NFFT / 2 + 63) return r;
        n = k - (NFFT / 2 - 63);
        if (sym == 0) begin
            b = xs[(n + 43 * nid2) % 127];
        end else begin
            m0 = 15 * (nid1 / 112) + 5 * nid2;
            m1 = nid1 % 112;
            b  = x0s[(n + m0) % 127] ^ x1s[(n + m1) % 127];
        end
        v = (b != 0) ? -AMP : AMP;
        r[OUT_DW/2-1:0] = v[OUT_DW/2-1:0];
        return r;
    endfunction

    task automatic find_bad(output int idx, output logic [BW-1:0] got, output logic [BW-1:0] exp);
        int b, j, e1, e2;
        logic [BW-1:0] e;
        idx = -1; got = '0; exp = '0;
        for (int i = 0; i < bq.size(); i++) begin
            b  = i / (2 * NFFT);
            j  = i % (2 * NFFT);
            e1 = reqs[b] >> 2;
            e2 = reqs[b] & 3;
            e  = model_beat(e1, e2, j / NFFT, j % NFFT);
            if (idx == -1 && bq[i] !== e) begin
                idx = i; got = bq[i]; exp = e;
            end
        end
    endtask

    function automatic int count_nz(int first);
        int c = 0;
        for (int i = first; i < first + NFFT && i < bq.size(); i++)
            if (bq[i][OUT_DW-1:0] != '0) c++;
        return c;
    endfunction

    // Drives the queued requests and collects accepted beats; outputs are
    // sampled on the falling edge, the handshake lands on the next rising edge.
    task automatic capture(input int target, input int min_cyc, input int max_cyc, input int mode);
        int req_idx = 0, ncyc = 0, stall_cnt = 0;
        bit hs_pend = 0, prev_stall = 0;
        logic [BW-1:0] prev = '0;
        bq.delete(); bq_cyc.delete(); err_cyc.delete();
        saw_valid = 0; saw_busy = 0; stab_err = 0;
        for (int i = 0; i < 8; i++) acc_edge[i] = -1;
        @(negedge clk);
        if (nreq > 0) begin ctrl_tdata = 11'(reqs[0]); ctrl_tvalid = 1'b1; end
        forever begin
            if (hs_pend) begin
                hs_pend = 0;
                req_idx++;
                if (req_idx < nreq) ctrl_tdata = 11'(reqs[req_idx]);
                else ctrl_tvalid = 1'b0;
            end
            if (ctrl_tvalid && ctrl_tready) begin hs_pend = 1; acc_edge[req_idx] = cyc + 1; end
            if (err) err_cyc.push_back(cyc);
            saw_valid |= out_tvalid;
            saw_busy  |= busy;
            if (prev_stall && (!out_tvalid || {out_tuser, out_tlast, out_tdata} !== prev)) stab_err++;
            if (mode == 0) out_tready = 1'b1;
            else if (out_tvalid && bq.size() == 255 && stall_cnt < 5) begin
                out_tready = 1'b0; stall_cnt++;
            end else out_tready = 1'($urandom_range(0, 1));
            if (out_tvalid && out_tready) begin
                bq.push_back({out_tuser, out_tlast, out_tdata});
                bq_cyc.push_back(cyc);
            end
            prev_stall = out_tvalid && !out_tready;
            prev = {out_tuser, out_tlast, out_tdata};
            ncyc++;
            if ((bq.size() >= target && req_idx >= nreq && !hs_pend && ncyc >= min_cyc) || ncyc >= max_cyc) break;
            @(negedge clk);
        end
        ctrl_tvalid = 1'b0;
        out_tready  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_tvalid, out_tlast, out_tuser, busy, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {out_tvalid, out_tlast, out_tuser, busy, err});
        end
        checks++;
        if (out_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", out_tdata); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_tready !== 1'b1 || out_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0", ctrl_tready, out_tvalid);
        end
    endtask

    task automatic test_basic();
        int idx; logic [BW-1:0] g, e; logic [BW-1:0] t;
        nreq = 1; reqs[0] = 0;
        capture(2 * NFFT, 0, 800, 0);
        checks++;
        if (bq.size() != 2 * NFFT) begin errors++; $display("FAIL basic_count: got %0d expected %0d", bq.size(), 2 * NFFT); end
        if (bq.size() == 2 * NFFT) begin
            checks++;
            if (bq_cyc[0] != acc_edge[0]) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", bq_cyc[0], acc_edge[0]); end
            checks++;
            if (bq_cyc[2*NFFT-1] - bq_cyc[0] != 2 * NFFT - 1) begin
                errors++; $display("FAIL basic_gapless: got %0d expected %0d", bq_cyc[2*NFFT-1] - bq_cyc[0], 2 * NFFT - 1);
            end
            t = bq[65];  checks++;
            if (t[15:0] !== 16'h2000) begin errors++; $display("FAIL pss_bin65: got %h expected 2000", t[15:0]); end
            t = bq[66];  checks++;
            if (t[15:0] !== 16'he000) begin errors++; $display("FAIL pss_bin66: got %h expected e000", t[15:0]); end
            t = bq[NFFT+65]; checks++;
            if (t[15:0] !== 16'h2000) begin errors++; $display("FAIL sss_bin65: got %h expected 2000", t[15:0]); end
            t = bq[NFFT+66]; checks++;
            if (t[15:0] !== 16'h2000) begin errors++; $display("FAIL sss_bin66: got %h expected 2000", t[15:0]); end
            t = bq[NFFT-1]; checks++;
            if (t[BW-1:OUT_DW] !== 2'b01) begin errors++; $display("FAIL pss_last: got %b expected 01", t[BW-1:OUT_DW]); end
            t = bq[2*NFFT-1]; checks++;
            if (t[BW-1:OUT_DW] !== 2'b11) begin errors++; $display("FAIL sss_last: got %b expected 11", t[BW-1:OUT_DW]); end
        end
        find_bad(idx, g, e);
        checks++;
        if (idx != -1) begin errors++; $display("FAIL basic_model beat %0d: got %h expected %h", idx, g, e); end
        @(negedge clk);
        checks++;
        if (out_tvalid !== 1'b0 || busy !== 1'b0 || ctrl_tready !== 1'b1) begin
            errors++; $display("FAIL basic_end: got valid=%b busy=%b ready=%b expected 0 0 1", out_tvalid, busy, ctrl_tready);
        end
    endtask

    task automatic test_ids();
        int ids1[4]; int idx, nz0, nz1; logic [BW-1:0] g, e;
        ids1 = '{0, 111, 112, 335};
        for (int n2 = 0; n2 < 3; n2++) begin
            for (int a = 0; a < 4; a++) begin
                nreq = 1; reqs[0] = (ids1[a] << 2) | n2;
                capture(2 * NFFT, 0, 800, 0);
                find_bad(idx, g, e);
                checks++;
                if (idx != -1 || bq.size() != 2 * NFFT) begin
                    errors++; $display("FAIL ids_model nid1=%0d nid2=%0d beat %0d n=%0d: got %h expected %h", ids1[a], n2, idx, bq.size(), g, e);
                end
                nz0 = count_nz(0); nz1 = count_nz(NFFT);
                checks++;
                if (nz0 != 127 || nz1 != 127) begin
                    errors++; $display("FAIL ids_nonzero nid1=%0d nid2=%0d: got %0d/%0d expected 127/127", ids1[a], n2, nz0, nz1);
                end
            end
        end
    endtask

    task automatic test_stall();
        int idx; logic [BW-1:0] g, e;
        nreq = 1; reqs[0] = ($urandom_range(0, 335) << 2) | $urandom_range(0, 2);
        capture(2 * NFFT, 0, 4000, 1);
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stab_err); end
        find_bad(idx, g, e);
        checks++;
        if (idx != -1 || bq.size() != 2 * NFFT) begin
            errors++; $display("FAIL stall_model beat %0d n=%0d: got %h expected %h", idx, bq.size(), g, e);
        end
    endtask

    task automatic test_illegal();
        nreq = 2; reqs[0] = (0 << 2) | 3; reqs[1] = (336 << 2) | 0;
        capture(0, 12, 40, 0);
        checks++;
        if (err_cyc.size() != 2) begin errors++; $display("FAIL illegal_err_count: got %0d expected 2", err_cyc.size()); end
        else begin
            checks++;
            if (err_cyc[0] != acc_edge[0] || err_cyc[1] != acc_edge[1]) begin
                errors++; $display("FAIL illegal_err_time: got %0d,%0d expected %0d,%0d", err_cyc[0], err_cyc[1], acc_edge[0], acc_edge[1]);
            end
        end
        checks++;
        if (saw_valid || saw_busy) begin errors++; $display("FAIL illegal_quiet: got valid=%b busy=%b expected 0 0", saw_valid, saw_busy); end
    endtask

    task automatic test_reset_mid();
        int idx; logic [BW-1:0] g, e;
        nreq = 1; reqs[0] = ($urandom_range(0, 335) << 2) | $urandom_range(0, 2);
        capture(101, 0, 400, 0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_tvalid, out_tlast, out_tuser, busy, err} !== 5'b0 || out_tdata !== '0) begin
            errors++; $display("FAIL midreset_outputs: got %b/%h expected 00000/0", {out_tvalid, out_tlast, out_tuser, busy, err}, out_tdata);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_tvalid !== 1'b0 || busy !== 1'b0 || out_tdata !== '0) begin
            errors++; $display("FAIL midreset_hold: got valid=%b busy=%b expected 0 0", out_tvalid, busy);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_noresume: got valid=%b busy=%b expected 0 0", out_tvalid, busy);
        end
        nreq = 1; reqs[0] = ($urandom_range(0, 335) << 2) | 1;
        capture(2 * NFFT, 0, 800, 0);
        find_bad(idx, g, e);
        checks++;
        if (idx != -1 || bq.size() != 2 * NFFT) begin
            errors++; $display("FAIL midreset_model beat %0d n=%0d: got %h expected %h", idx, bq.size(), g, e);
        end
    endtask

    task automatic test_back_to_back();
        int idx; logic [BW-1:0] g, e;
        nreq = 2;
        reqs[0] = ($urandom_range(0, 335) << 2) | $urandom_range(0, 2);
        reqs[1] = ($urandom_range(0, 335) << 2) | $urandom_range(0, 2);
        capture(4 * NFFT, 0, 1600, 0);
        checks++;
        if (bq.size() != 4 * NFFT) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", bq.size(), 4 * NFFT); end
        else begin
            checks++;
            if (acc_edge[1] != bq_cyc[2*NFFT-1] + 2) begin
                errors++; $display("FAIL b2b_accept: got %0d expected %0d", acc_edge[1], bq_cyc[2*NFFT-1] + 2);
            end
            checks++;
            if (bq_cyc[2*NFFT] != bq_cyc[2*NFFT-1] + 2) begin
                errors++; $display("FAIL b2b_first_beat: got %0d expected %0d", bq_cyc[2*NFFT], bq_cyc[2*NFFT-1] + 2);
            end
        end
        find_bad(idx, g, e);
        checks++;
        if (idx != -1) begin errors++; $display("FAIL b2b_model beat %0d: got %h expected %h", idx, g, e); end
    endtask

    initial begin
        build_seqs();
        test_reset();
        test_basic();
        test_ids();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
